tug_scoreboard: RTL and testbench



---
 rtl/tug_scoreboard.sv | 127 ++++++++++++
 tb/tb_tug_scoreboard.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tug_scoreboard.sv
// Tug-of-war round/match controller: awards points, pauses, restarts rounds, tracks the winner.
// Optional rematch via L&R in OVER when TUG_SCOREBOARD_REMATCH_EN is defined.
module tug_scoreboard #(
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic               leftEnd,
  input  logic               rightEnd,
  output logic               next,
  output logic [SCORE_W-1:0] leftScore,
  output logic [SCORE_W-1:0] rightScore,
  output logic               gameOver,
  output logic               leftWon
);

  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HLD0 = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SCORE_W-1:0] left_q, left_d, right_q, right_d;
  logic               next_q, next_d;
  logic               over_q, over_d;
  logic               won_q, won_d;

  logic               left_pt, right_pt;
  logic [SCORE_W-1:0] left_inc, right_inc;

  assign left_pt   = leftEnd  & L & ~R;
  assign right_pt  = rightEnd & R & ~L;
  assign left_inc  = left_q  + SCORE_W'(1);
  assign right_inc = right_q + SCORE_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    left_d  = left_q;
    right_d = right_q;
    next_d  = 1'b0;
    over_d  = over_q;
    won_d   = won_q;
    unique case (state_q)
      PLAY: begin
        // The cells clear on the edge that ends next, so an end light seen then is stale.
        if (!next_q) begin
          if (left_pt) begin
            left_d = left_inc;
            if (left_inc == WIN) begin
              state_d = OVER;
              over_d  = 1'b1;
              won_d   = 1'b1;
            end else begin
              state_d = HOLD;
              hold_d  = HLD0;
            end
          end else if (right_pt) begin
            right_d = right_inc;
            if (right_inc == WIN) begin
              state_d = OVER;
              over_d  = 1'b1;
              won_d   = 1'b0;
            end else begin
              state_d = HOLD;
              hold_d  = HLD0;
            end
          end
        end
      end
      HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          next_d  = 1'b1;
          state_d = PLAY;
        end
      end
      OVER: begin
`ifdef TUG_SCOREBOARD_REMATCH_EN
        if (L & R) begin
          left_d  = '0;
          right_d = '0;
          over_d  = 1'b0;
          won_d   = 1'b0;
          next_d  = 1'b1;
          state_d = PLAY;
        end
`endif
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= PLAY;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      next_q  <= 1'b0;
      over_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      right_q <= right_d;
      next_q  <= next_d;
      over_q  <= over_d;
      won_q   <= won_d;
    end
  end

  assign next       = next_q;
  assign leftScore  = left_q;
  assign rightScore = right_q;
  assign gameOver   = over_q;
  assign leftWon    = won_q;

endmodule

// File: tb/tb_tug_scoreboard.sv
// Directed + randomized bench for tug_scoreboard against a timing-rule reference model.
module tb_tug_scoreboard;
  localparam int SCORE_W = 3, WIN_SCORE = 7, HOLD_CYCLES = 4;

  logic Clock = 1'b0, Reset, L, R, leftEnd, rightEnd;
  logic next, gameOver, leftWon;
  logic [SCORE_W-1:0] leftScore, rightScore;

  tug_scoreboard #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .Clock(Clock), .Reset(Reset), .L(L), .R(R), .leftEnd(leftEnd), .rightEnd(rightEnd),
    .next(next), .leftScore(leftScore), .rightScore(rightScore),
    .gameOver(gameOver), .leftWon(leftWon)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a point at edge t schedules next for edge t+HOLD_CYCLES; nothing scores
  // while a restart is pending, during the next cycle, or after the match ends.
  int m_l, m_r, due, cyc, n_next;
  bit m_over, m_won, m_next;

  task automatic model(input bit rst, input bit l, input bit r, input bit le, input bit re);
    bit nn;
    nn = 1'b0;
    if (rst) begin
      m_l = 0; m_r = 0; m_over = 0; m_won = 0; due = -1;
    end else if (m_over) begin
`ifdef TUG_SCOREBOARD_REMATCH_EN
      if (l && r) begin
        m_l = 0; m_r = 0; m_over = 0; m_won = 0; nn = 1'b1;
      end
`endif
    end else if (due >= 0) begin
      if (cyc == due) begin nn = 1'b1; due = -1; end
    end else if (!m_next) begin
      if (le && l && !r) begin
        m_l++;
        if (m_l == WIN_SCORE) begin m_over = 1; m_won = 1; end
        else due = cyc + HOLD_CYCLES;
      end else if (re && r && !l) begin
        m_r++;
        if (m_r == WIN_SCORE) begin m_over = 1; m_won = 0; end
        else due = cyc + HOLD_CYCLES;
      end
    end
    m_next = nn;
  endtask

  task automatic step(input bit rst, input bit l, input bit r, input bit le, input bit re);
    Reset = rst; L = l; R = r; leftEnd = le; rightEnd = re;
    @(posedge Clock);
    model(rst, l, r, le, re);
    cyc++;
    #1;
    if (next) n_next++;
    chk("next", int'(next), int'(m_next));
    chk("leftScore", int'(leftScore), m_l);
    chk("rightScore", int'(rightScore), m_r);
    chk("gameOver", int'(gameOver), int'(m_over));
    if (m_over) chk("leftWon", int'(leftWon), int'(m_won));
    else        chk("leftWon_clr", int'(leftWon), 0);
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int np;
    Reset = 1; L = 0; R = 0; leftEnd = 0; rightEnd = 0;
    m_l = 0; m_r = 0; m_over = 0; m_won = 0; m_next = 0; due = -1; cyc = 0; n_next = 0;
    @(negedge Clock);
    step(1, 0, 0, 0, 0);
    idle(10);
    chk("idle_no_next", n_next, 0);

    // Left point, key activity during HOLD and during the next cycle.
    n_next = 0;
    step(0, 1, 0, 1, 0);
    chk("left_pt", int'(leftScore), 1);
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0);
    idle(1);
    chk("no_next_yet", int'(next), 0);
    step(0, 1, 0, 1, 0);
    chk("next_at_E4", int'(next), 1);
    step(0, 1, 0, 1, 0);
    chk("next_one_cycle", int'(next), 0);
    idle(6);
    chk("single_next", n_next, 1);
    chk("left_after_hold", int'(leftScore), 1);

    // L&R with leftEnd scores nothing.
    step(0, 1, 1, 1, 1);
    idle(6);

    // Reset two cycles into HOLD.
    step(0, 0, 1, 0, 1);
    idle(2);
    n_next = 0;
    step(1, 0, 0, 0, 0);
    idle(8);
    chk("rst_hold_no_next", n_next, 0);

    // Seven right points win the match.
    n_next = 0;
    for (int k = 0; k < WIN_SCORE; k++) begin
      step(0, 0, 1, 0, 1);
      idle(HOLD_CYCLES + 2);
    end
    chk("right_win_score", int'(rightScore), WIN_SCORE);
    chk("right_win_over", int'(gameOver), 1);
    chk("right_win_nexts", n_next, WIN_SCORE - 1);
    for (int i = 0; i < 20; i++)
      step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    step(0, 1, 1, 0, 0);
    idle(3);

    // Randomized play with occasional reset.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      np = $urandom_range(0, 99);
      step(np == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
